// File: rtl/merger_2way_if.sv
// Port bundle for merger_2way: two FWFT upstream FIFO ports, the downstream
// write port and per-run statistics.
interface merger_2way_if #(
    parameter int unsigned DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] i_fifo_1;
    logic                  i_fifo_1_empty;
    logic                  o_fifo_1_read;
    logic [DATA_WIDTH-1:0] i_fifo_2;
    logic                  i_fifo_2_empty;
    logic                  o_fifo_2_read;
    logic                  i_fifo_out_ready;
    logic                  o_out_fifo_write;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_run_done;
    logic [31:0]           o_run_len;

    modport slave (
        input  i_fifo_1, i_fifo_1_empty, i_fifo_2, i_fifo_2_empty, i_fifo_out_ready,
        output o_fifo_1_read, o_fifo_2_read, o_out_fifo_write, o_data, o_run_done, o_run_len
    );

    modport master (
        output i_fifo_1, i_fifo_1_empty, i_fifo_2, i_fifo_2_empty, i_fifo_out_ready,
        input  o_fifo_1_read, o_fifo_2_read, o_out_fifo_write, o_data, o_run_done, o_run_len
    );
endinterface

// File: rtl/merger_2way.sv
// Two-input merge node of the sort tree: merges two sorted runs (all-zero record
// terminates a run) into one run, one record per cycle, with run length reporting.

module merger_2way_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    // Extra pointer bit distinguishes full from empty after wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (i_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;
endmodule

module merger_2way #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEY_WIDTH  = 80,
    parameter int unsigned IN_DEPTH   = 16,
    parameter int unsigned OUT_DEPTH  = 32,
    parameter int unsigned DESCENDING = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    merger_2way_if.slave  bus
);
    localparam int unsigned IAW = $clog2(IN_DEPTH);
    localparam int unsigned OAW = $clog2(OUT_DEPTH);
    localparam int unsigned CW  = 32;

    typedef enum logic [1:0] {
        S_MERGE   = 2'd0,
        S_DRAIN_A = 2'd1,
        S_DRAIN_B = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] w_head_a;
    logic [DATA_WIDTH-1:0] w_head_b;
    logic [IAW:0]          w_cnt_a;
    logic [IAW:0]          w_cnt_b;
    logic                  w_empty_a;
    logic                  w_empty_b;
    logic                  w_full_a;
    logic                  w_full_b;
    logic                  w_in_rd_1;
    logic                  w_in_rd_2;

    logic [DATA_WIDTH-1:0] w_out_head;
    logic [OAW:0]          w_out_cnt;
    logic                  w_out_empty;
    logic                  w_out_rd;
    logic                  w_room;

    logic [KEY_WIDTH-1:0]  w_key_a;
    logic [KEY_WIDTH-1:0]  w_key_b;
    logic                  w_term_a;
    logic                  w_term_b;
    logic                  w_avail_both;
    logic                  w_pick_a;

    logic                  w_pop_a;
    logic                  w_pop_b;
    logic                  w_emit;
    logic                  w_emit_term;
    logic [DATA_WIDTH-1:0] w_emit_data;

    logic                  r_sel_valid;
    logic [DATA_WIDTH-1:0] r_sel_data;
    logic                  r_ready_q;
    logic [CW-1:0]         r_run_cnt;
    logic [CW-1:0]         r_run_len;
    logic                  r_run_done;

    // Input side: pull from upstream whenever the internal FIFO has space.
    assign w_empty_a = (w_cnt_a == '0);
    assign w_empty_b = (w_cnt_b == '0);
    assign w_full_a  = (w_cnt_a == (IAW+1)'(IN_DEPTH));
    assign w_full_b  = (w_cnt_b == (IAW+1)'(IN_DEPTH));
    assign w_in_rd_1 = ~i_rst & ~bus.i_fifo_1_empty & ~w_full_a;
    assign w_in_rd_2 = ~i_rst & ~bus.i_fifo_2_empty & ~w_full_b;

    merger_2way_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_fifo_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (w_in_rd_1),
        .i_data  (bus.i_fifo_1),
        .i_rd    (w_pop_a),
        .o_head  (w_head_a),
        .o_count (w_cnt_a)
    );

    merger_2way_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(IN_DEPTH)) u_fifo_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (w_in_rd_2),
        .i_data  (bus.i_fifo_2),
        .i_rd    (w_pop_b),
        .o_head  (w_head_b),
        .o_count (w_cnt_b)
    );

    assign w_key_a      = w_head_a[KEY_WIDTH-1:0];
    assign w_key_b      = w_head_b[KEY_WIDTH-1:0];
    assign w_term_a     = (w_head_a == '0);
    assign w_term_b     = (w_head_b == '0);
    assign w_avail_both = ~w_empty_a & ~w_empty_b;
    // Ties resolve to input A in both directions.
    assign w_pick_a     = (DESCENDING != 0) ? (w_key_a >= w_key_b) : (w_key_a <= w_key_b);
    // Two free slots: one for the record in the selection register, one for this pick.
    assign w_room       = (w_out_cnt <= (OAW+1)'(OUT_DEPTH - 2));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_MERGE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_room) begin
            case (r_state)
                S_MERGE: begin
                    if (w_avail_both && (w_term_a != w_term_b))
                        w_state_nxt = w_term_a ? S_DRAIN_B : S_DRAIN_A;
                end
                S_DRAIN_A: begin
                    if (!w_empty_a && w_term_a && !w_empty_b) w_state_nxt = S_MERGE;
                end
                S_DRAIN_B: begin
                    if (!w_empty_b && w_term_b && !w_empty_a) w_state_nxt = S_MERGE;
                end
                default: w_state_nxt = S_MERGE;
            endcase
        end
    end

    // Pop/emit decisions; a terminator pair collapses into a single emitted terminator.
    always_comb begin
        w_pop_a     = 1'b0;
        w_pop_b     = 1'b0;
        w_emit      = 1'b0;
        w_emit_term = 1'b0;
        w_emit_data = '0;
        if (w_room) begin
            case (r_state)
                S_MERGE: begin
                    if (w_avail_both) begin
                        if (w_term_a && w_term_b) begin
                            w_pop_a     = 1'b1;
                            w_pop_b     = 1'b1;
                            w_emit      = 1'b1;
                            w_emit_term = 1'b1;
                        end else if (!w_term_a && !w_term_b) begin
                            w_emit = 1'b1;
                            if (w_pick_a) begin
                                w_pop_a     = 1'b1;
                                w_emit_data = w_head_a;
                            end else begin
                                w_pop_b     = 1'b1;
                                w_emit_data = w_head_b;
                            end
                        end
                    end
                end
                S_DRAIN_A: begin
                    if (!w_empty_a && !w_term_a) begin
                        w_pop_a     = 1'b1;
                        w_emit      = 1'b1;
                        w_emit_data = w_head_a;
                    end else if (!w_empty_a && !w_empty_b) begin
                        w_pop_a     = 1'b1;
                        w_pop_b     = 1'b1;
                        w_emit      = 1'b1;
                        w_emit_term = 1'b1;
                    end
                end
                S_DRAIN_B: begin
                    if (!w_empty_b && !w_term_b) begin
                        w_pop_b     = 1'b1;
                        w_emit      = 1'b1;
                        w_emit_data = w_head_b;
                    end else if (!w_empty_b && !w_empty_a) begin
                        w_pop_a     = 1'b1;
                        w_pop_b     = 1'b1;
                        w_emit      = 1'b1;
                        w_emit_term = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Selection register, downstream ready pipeline and run statistics.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel_valid <= 1'b0;
            r_sel_data  <= '0;
            r_ready_q   <= 1'b0;
            r_run_cnt   <= '0;
            r_run_len   <= '0;
            r_run_done  <= 1'b0;
        end else begin
            r_ready_q   <= bus.i_fifo_out_ready;
            r_sel_valid <= w_emit;
            r_run_done  <= w_emit & w_emit_term;
            if (w_emit) begin
                r_sel_data <= w_emit_data;
                if (w_emit_term) begin
                    r_run_len <= r_run_cnt;
                    r_run_cnt <= '0;
                end else if (r_run_cnt != '1) begin
                    r_run_cnt <= r_run_cnt + CW'(1);
                end
            end
        end
    end

    merger_2way_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(OUT_DEPTH)) u_fifo_out (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (r_sel_valid),
        .i_data  (r_sel_data),
        .i_rd    (w_out_rd),
        .o_head  (w_out_head),
        .o_count (w_out_cnt)
    );

    assign w_out_empty = (w_out_cnt == '0);
    assign w_out_rd    = r_ready_q & ~w_out_empty;

    assign bus.o_fifo_1_read    = w_in_rd_1;
    assign bus.o_fifo_2_read    = w_in_rd_2;
    assign bus.o_out_fifo_write = w_out_rd;
    assign bus.o_data           = w_out_empty ? '0 : w_out_head;
    assign bus.o_run_done       = r_run_done;
    assign bus.o_run_len        = r_run_len;
endmodule

// File: tb/tb_merger_2way.sv
// Bench for merger_2way: an ascending and a descending instance fed from queue
// sources, with a reference merge filling the expected-output scoreboard.
module tb_merger_2way;
    localparam int unsigned DW = 128;
    localparam int unsigned KW = 80;
    typedef logic [DW-1:0] rec_t;

    logic clk;
    logic rst;
    logic ready;
    int   n_checks;
    int   n_err;
    int   n_wr [2];

    rec_t        src_a [2][$];
    rec_t        src_b [2][$];
    rec_t        exp_q [2][$];
    logic [31:0] len_q [2][$];
    rec_t        stg_a [$];
    rec_t        stg_b [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 2; g++) begin : gi
        merger_2way_if #(.DATA_WIDTH(DW)) bus ();
        logic        m_rdy;
        rec_t        e_rec;
        logic [31:0] e_len;

        merger_2way #(
            .DATA_WIDTH(DW), .KEY_WIDTH(KW), .IN_DEPTH(16), .OUT_DEPTH(32), .DESCENDING(g)
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst),
            .bus   (bus)
        );

        assign bus.i_fifo_out_ready = ready;

        // Upstream FWFT heads are presented on the falling edge.
        always @(negedge clk) begin
            bus.i_fifo_1       = (src_a[g].size() != 0) ? src_a[g][0] : '0;
            bus.i_fifo_1_empty = (src_a[g].size() == 0);
            bus.i_fifo_2       = (src_b[g].size() != 0) ? src_b[g][0] : '0;
            bus.i_fifo_2_empty = (src_b[g].size() == 0);
        end

        always @(posedge clk) begin
            m_rdy = rst ? 1'b0 : ready;
            if (bus.o_fifo_1_read === 1'b1) void'(src_a[g].pop_front());
            if (bus.o_fifo_2_read === 1'b1) void'(src_b[g].pop_front());
        end

        always @(negedge clk) begin
            if (rst === 1'b0) begin
                if (bus.o_out_fifo_write === 1'b1) begin
                    n_wr[g]++;
                    n_checks++;
                    assert (m_rdy === 1'b1) else begin
                        n_err++;
                        $error("FAIL wr_ready_q[%0d] got %b exp 1", g, m_rdy);
                    end
                    n_checks++;
                    assert (exp_q[g].size() != 0) else begin
                        n_err++;
                        $error("FAIL extra_write[%0d] got %h exp none", g, bus.o_data);
                    end
                    if (exp_q[g].size() != 0) begin
                        e_rec = exp_q[g].pop_front();
                        n_checks++;
                        assert (bus.o_data === e_rec) else begin
                            n_err++;
                            $error("FAIL data[%0d] got %h exp %h", g, bus.o_data, e_rec);
                        end
                    end
                end
                if (bus.o_run_done === 1'b1) begin
                    n_checks++;
                    assert (len_q[g].size() != 0) else begin
                        n_err++;
                        $error("FAIL extra_run_done[%0d] got len %0d exp none", g, bus.o_run_len);
                    end
                    if (len_q[g].size() != 0) begin
                        e_len = len_q[g].pop_front();
                        n_checks++;
                        assert (bus.o_run_len === e_len) else begin
                            n_err++;
                            $error("FAIL run_len[%0d] got %0d exp %0d", g, bus.o_run_len, e_len);
                        end
                    end
                end
            end
        end
    end

    function automatic rec_t mk(input logic [7:0] tag, input logic [KW-1:0] key);
        rec_t r;
        r = '0;
        r[KW-1:0] = key;
        r[KW+7:KW] = tag;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s got %h exp %h", name, got, expv);
        end
    endtask

    // Queue the staged runs (plus terminators) and the reference merge result.
    task automatic send(input int g, input bit desc);
        int i;
        int j;
        bit take_a;
        i = 0;
        j = 0;
        foreach (stg_a[k]) src_a[g].push_back(stg_a[k]);
        foreach (stg_b[k]) src_b[g].push_back(stg_b[k]);
        src_a[g].push_back('0);
        src_b[g].push_back('0);
        while (i < stg_a.size() || j < stg_b.size()) begin
            if (j >= stg_b.size())      take_a = 1'b1;
            else if (i >= stg_a.size()) take_a = 1'b0;
            else if (desc)              take_a = (stg_a[i][KW-1:0] >= stg_b[j][KW-1:0]);
            else                        take_a = (stg_a[i][KW-1:0] <= stg_b[j][KW-1:0]);
            if (take_a) begin
                exp_q[g].push_back(stg_a[i]);
                i++;
            end else begin
                exp_q[g].push_back(stg_b[j]);
                j++;
            end
        end
        exp_q[g].push_back('0);
        len_q[g].push_back(32'(stg_a.size() + stg_b.size()));
        stg_a.delete();
        stg_b.delete();
    endtask

    task automatic wait_idle(input int g, input int budget, input string tag);
        int c;
        c = 0;
        while ((exp_q[g].size() != 0 || len_q[g].size() != 0) && c < budget) begin
            tick();
            c++;
        end
        n_checks++;
        assert (exp_q[g].size() == 0 && len_q[g].size() == 0) else begin
            n_err++;
            $error("FAIL drain_%s got %0d pending exp 0", tag, exp_q[g].size() + len_q[g].size());
        end
    endtask

    initial begin
        int base;
        int c;
        rst      = 1'b1;
        ready    = 1'b0;
        n_checks = 0;
        n_err    = 0;
        n_wr[0]  = 0;
        n_wr[1]  = 0;

        // Ascending run staged while reset holds the upstream reads off.
        stg_a.push_back(mk(8'hA1, KW'(1)));
        stg_a.push_back(mk(8'hA1, KW'(4)));
        stg_a.push_back(mk(8'hA1, KW'(7)));
        stg_b.push_back(mk(8'hB1, KW'(2)));
        stg_b.push_back(mk(8'hB1, KW'(3)));
        stg_b.push_back(mk(8'hB1, KW'(9)));
        send(0, 1'b0);
        repeat (3) tick();
        chk("rst_read_1", DW'(gi[0].bus.o_fifo_1_read), DW'(0));
        chk("rst_read_2", DW'(gi[0].bus.o_fifo_2_read), DW'(0));
        chk("rst_write", DW'(gi[0].bus.o_out_fifo_write), DW'(0));
        chk("rst_data", gi[0].bus.o_data, DW'(0));
        chk("rst_run_done", DW'(gi[0].bus.o_run_done), DW'(0));
        chk("rst_run_len", DW'(gi[0].bus.o_run_len), DW'(0));
        rst   = 1'b0;
        ready = 1'b1;
        wait_idle(0, 200, "asc");
        chk("asc_run_len", DW'(gi[0].bus.o_run_len), DW'(6));

        // Descending with a key tie between the inputs.
        stg_a.push_back(mk(8'hA2, KW'(9)));
        stg_a.push_back(mk(8'hA2, KW'(5)));
        stg_b.push_back(mk(8'hB2, KW'(8)));
        stg_b.push_back(mk(8'hB2, KW'(5)));
        stg_b.push_back(mk(8'hB2, KW'(1)));
        send(1, 1'b1);
        wait_idle(1, 200, "desc");
        chk("desc_run_len", DW'(gi[1].bus.o_run_len), DW'(5));

        // Key 0 with non-zero payload is data, not a terminator.
        stg_a.push_back(mk(8'h55, KW'(0)));
        send(0, 1'b0);
        wait_idle(0, 200, "key0");
        chk("key0_run_len", DW'(gi[0].bus.o_run_len), DW'(1));

        // Drain of B after an empty A run, then a back-to-back second run.
        stg_b.push_back(mk(8'hB3, KW'(3)));
        stg_b.push_back(mk(8'hB3, KW'(6)));
        stg_b.push_back(mk(8'hB3, KW'(8)));
        send(0, 1'b0);
        stg_a.push_back(mk(8'hA4, KW'(2)));
        stg_b.push_back(mk(8'hB4, KW'(1)));
        send(0, 1'b0);
        wait_idle(0, 200, "drain");
        chk("drain_run_len", DW'(gi[0].bus.o_run_len), DW'(2));

        // Latency and full throughput with both inputs supplied.
        for (int i = 0; i < 20; i++) begin
            stg_a.push_back(mk(8'hA5, KW'(2 * i + 2)));
            stg_b.push_back(mk(8'hB5, KW'(2 * i + 3)));
        end
        send(0, 1'b0);
        c = 0;
        while (gi[0].bus.o_out_fifo_write !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk("latency", DW'(c), DW'(3));
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("throughput", DW'(gi[0].bus.o_out_fifo_write), DW'(1));
        end
        wait_idle(0, 200, "tput");

        // Backpressure: long hold low, then random ready.
        ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            stg_a.push_back(mk(8'hA6, KW'(4 * i + 1 + 2 * $urandom_range(0, 1))));
            stg_b.push_back(mk(8'hB6, KW'(4 * i + 2)));
        end
        base = n_wr[0];
        send(0, 1'b0);
        repeat (40) tick();
        chk("bp_read_1_full", DW'(gi[0].bus.o_fifo_1_read), DW'(0));
        chk("bp_read_2_full", DW'(gi[0].bus.o_fifo_2_read), DW'(0));
        chk("bp_hold_writes", DW'(n_wr[0] - base), DW'(0));
        c = 0;
        while (exp_q[0].size() != 0 && c < 3000) begin
            ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        ready = 1'b1;
        wait_idle(0, 200, "bp");
        chk("bp_count", DW'(n_wr[0] - base), DW'(129));

        // Reset in the middle of a run discards everything buffered.
        for (int i = 0; i < 30; i++) begin
            stg_a.push_back(mk(8'hA7, KW'(2 * i + 2)));
            stg_b.push_back(mk(8'hB7, KW'(2 * i + 3)));
        end
        base = n_wr[0];
        send(0, 1'b0);
        c = 0;
        while ((n_wr[0] - base) < 10 && c < 200) begin
            tick();
            c++;
        end
        chk("mid_reached_10", DW'((n_wr[0] - base) >= 10), DW'(1));
        tick();
        rst = 1'b1;
        src_a[0].delete();
        src_b[0].delete();
        exp_q[0].delete();
        len_q[0].delete();
        tick();
        chk("mid_rst_write", DW'(gi[0].bus.o_out_fifo_write), DW'(0));
        chk("mid_rst_data", gi[0].bus.o_data, DW'(0));
        chk("mid_rst_run_done", DW'(gi[0].bus.o_run_done), DW'(0));
        chk("mid_rst_run_len", DW'(gi[0].bus.o_run_len), DW'(0));
        rst = 1'b0;
        stg_a.push_back(mk(8'hA8, KW'(5)));
        stg_b.push_back(mk(8'hB8, KW'(6)));
        send(0, 1'b0);
        wait_idle(0, 200, "post_rst");
        chk("post_rst_run_len", DW'(gi[0].bus.o_run_len), DW'(2));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
